// File: rtl/pwm_multigen_peripheral_if.sv
// Register-file side of the multi-generator PWM engine: shadowed configuration in, pins and period pulses out.
// Optional macro PWM_POLARITY_EN adds the per-pin polarity input pol.
interface pwm_multigen_peripheral_if #(
   parameter int NUM_GEN    = 2,
   parameter int CH_PER_GEN = 2,
   parameter int NUM_OUT    = 8,
   parameter int CNT_W      = 8,
   parameter int DIV_W      = 4
);
   localparam int NUM_CH = NUM_GEN * CH_PER_GEN;
   localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [NUM_OUT-1:0]        en_out;
   logic [NUM_OUT-1:0]        en_pwm_out;
   logic [NUM_OUT*SEL_W-1:0]  out_sel;
   logic [NUM_CH*CNT_W-1:0]   duty;
   logic [NUM_GEN*CNT_W-1:0]  top;
   logic [NUM_GEN*DIV_W-1:0]  div;
   logic [NUM_GEN-1:0]        mode;
`ifdef PWM_POLARITY_EN
   logic [NUM_OUT-1:0]        pol;
`endif
   logic [NUM_GEN-1:0]        period_start;
   logic [NUM_OUT-1:0]        out;

   modport master (
      output en_out, en_pwm_out, out_sel, duty, top, div, mode,
`ifdef PWM_POLARITY_EN
      output pol,
`endif
      input  period_start, out
   );

   modport slave (
      input  en_out, en_pwm_out, out_sel, duty, top, div, mode,
`ifdef PWM_POLARITY_EN
      input  pol,
`endif
      output period_start, out
   );
endinterface

// File: rtl/pwm_multigen_peripheral.sv
// Multi-generator PWM engine: per-generator prescaler, edge/centre counter, double-buffered settings, pin crossbar.
// Optional macro PWM_POLARITY_EN enables per-pin output inversion on PWM-driven pins.
module pwm_multigen_peripheral #(
   parameter int NUM_GEN    = 2,
   parameter int CH_PER_GEN = 2,
   parameter int NUM_OUT    = 8,
   parameter int CNT_W      = 8,
   parameter int DIV_W      = 4
) (
   input  logic clk,
   input  logic rst_n,
   pwm_multigen_peripheral_if.slave bus
);
   localparam int NUM_CH = NUM_GEN * CH_PER_GEN;
   localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int PSC_W  = 1 << DIV_W;
   localparam int PAD_W  = 1 << SEL_W;

   function automatic logic cmp_duty(input logic [CNT_W-1:0] cnt, input logic [CNT_W-1:0] duty_v);
      return cnt < duty_v;
   endfunction

   logic [NUM_CH-1:0]  pwm_p0;
   logic [NUM_GEN-1:0] period_start_p1;

   for (genvar g = 0; g < NUM_GEN; g++) begin : gen_g
      logic [PSC_W-1:0] psc_p0;
      logic [CNT_W-1:0] cnt_p0;
      logic [CNT_W-1:0] top_a;
      logic [DIV_W-1:0] div_a;
      logic             mode_a;
      logic             dir_p0;
      logic             ps_p1;
      logic [CNT_W-1:0] duty_a [CH_PER_GEN];
      logic             tick;
      logic             down;
      logic             bnd;

      assign tick = (psc_p0 == ((PSC_W'(1) << div_a) - PSC_W'(1)));
      // Centre mode turns around on reaching TOP, so TOP=1 also ends its period on the way down.
      assign down = mode_a & (dir_p0 | (cnt_p0 >= top_a));
      assign bnd  = tick & ((top_a == '0) |
                            (mode_a ? (down & (cnt_p0 == CNT_W'(1))) : (cnt_p0 >= top_a)));

      // Stage p0: prescaler, counter and shadow registers
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            psc_p0 <= '0;
            cnt_p0 <= '0;
            top_a  <= '0;
            div_a  <= '0;
            mode_a <= 1'b0;
            dir_p0 <= 1'b0;
            ps_p1  <= 1'b0;
            for (int c = 0; c < CH_PER_GEN; c++) duty_a[c] <= '0;
         end else begin
            ps_p1 <= bnd;
            if (bnd) begin
               psc_p0 <= '0;
               cnt_p0 <= '0;
               dir_p0 <= 1'b0;
               top_a  <= bus.top[g*CNT_W +: CNT_W];
               div_a  <= bus.div[g*DIV_W +: DIV_W];
               mode_a <= bus.mode[g];
               for (int c = 0; c < CH_PER_GEN; c++)
                  duty_a[c] <= bus.duty[(g*CH_PER_GEN+c)*CNT_W +: CNT_W];
            end else if (tick) begin
               psc_p0 <= '0;
               if (down) begin
                  cnt_p0 <= cnt_p0 - CNT_W'(1);
                  dir_p0 <= 1'b1;
               end else begin
                  cnt_p0 <= cnt_p0 + CNT_W'(1);
               end
            end else begin
               psc_p0 <= psc_p0 + PSC_W'(1);
            end
         end
      end

      assign period_start_p1[g] = ps_p1;
      for (genvar c = 0; c < CH_PER_GEN; c++) begin : gen_c
         assign pwm_p0[g*CH_PER_GEN+c] = cmp_duty(cnt_p0, duty_a[c]);
      end
   end

   // Out-of-range selects land in the zero padding.
   logic [PAD_W-1:0]   pwm_pad;
   logic [NUM_OUT-1:0] out_d;
   logic [NUM_OUT-1:0] out_p1;

   assign pwm_pad = PAD_W'(pwm_p0);

   always_comb begin
      out_d = '0;
      for (int p = 0; p < NUM_OUT; p++) begin
         if (bus.en_pwm_out[p] & bus.en_out[p])
`ifdef PWM_POLARITY_EN
            out_d[p] = pwm_pad[bus.out_sel[p*SEL_W +: SEL_W]] ^ bus.pol[p];
`else
            out_d[p] = pwm_pad[bus.out_sel[p*SEL_W +: SEL_W]];
`endif
         else
            out_d[p] = bus.en_out[p];
      end
   end

   // Stage p1: registered pin outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) out_p1 <= '0;
      else        out_p1 <= out_d;
   end

   assign bus.out          = out_p1;
   assign bus.period_start = period_start_p1;
endmodule
